// File: rtl/uart_tx_arb.sv
// Two-requester byte arbiter feeding a 4-entry FIFO that drives a UART transmitter
// start/acknowledge handshake. Define UART_TX_ARB_RR_EN for round-robin arbitration.
module uart_tx_arb #(
    parameter logic [15:0] ACK_TIMEOUT = 16'd65535
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    output logic       req1_ready,
    output logic [7:0] txData,
    output logic       txStart,
    input  logic       clrTxStartBit,
    input  logic       err_clr,
    output logic       tx_err,
    output logic [2:0] fifo_count,
    output logic       fifo_empty,
    output logic       fifo_full
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_ACK  = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  mem_q [4];
    logic [1:0]  wr_ptr_q, wr_ptr_d;
    logic [1:0]  rd_ptr_q, rd_ptr_d;
    logic [2:0]  count_q, count_d;
    logic [15:0] cnt_q, cnt_d;
    logic        tx_start_q, tx_start_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        tx_err_q, tx_err_d;

    logic        grant0_s, grant1_s;
    logic        full_s;
    logic        push_s, pop_s, timeout_s;
    logic [7:0]  push_data_s;

`ifdef UART_TX_ARB_RR_EN
    // rr_q set means requester 1 wins the next contended cycle.
    logic        rr_q, rr_d;

    // Round-robin grant: contention is resolved by the favour bit.
    always_comb begin
        grant0_s = req0_valid & (~req1_valid | ~rr_q);
        grant1_s = req1_valid & (~req0_valid | rr_q);
    end

    // Favour the requester that did not win the last accepted push.
    always_comb begin
        rr_d = rr_q;
        if (req0_valid && req0_ready) begin
            rr_d = 1'b1;
        end else if (req1_valid && req1_ready) begin
            rr_d = 1'b0;
        end else begin
            rr_d = rr_q;
        end
    end
`else
    // Fixed priority grant: requester 0 always wins.
    always_comb begin
        grant0_s = req0_valid;
        grant1_s = req1_valid & ~req0_valid;
    end
`endif

    assign full_s     = (count_q == 3'd4);
    assign req0_ready = grant0_s & ~full_s;
    assign req1_ready = grant1_s & ~full_s;
    assign push_s     = (req0_valid & req0_ready) | (req1_valid & req1_ready);

    // Select the byte of whichever requester holds the grant.
    always_comb begin
        if (grant0_s) begin
            push_data_s = req0_data;
        end else begin
            push_data_s = req1_data;
        end
    end

    // Transmitter handshake FSM; ack is checked before timeout so a late ack still counts.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        tx_start_d = tx_start_q;
        tx_data_d  = tx_data_q;
        pop_s      = 1'b0;
        timeout_s  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (count_q != 3'd0) begin
                    state_d    = S_ACK;
                    tx_start_d = 1'b1;
                    tx_data_d  = mem_q[rd_ptr_q];
                    cnt_d      = 16'd0;
                end else begin
                    tx_start_d = 1'b0;
                end
            end
            S_ACK: begin
                if (clrTxStartBit) begin
                    pop_s      = 1'b1;
                    tx_start_d = 1'b0;
                    state_d    = S_IDLE;
                    cnt_d      = 16'd0;
                end else if (cnt_q >= (ACK_TIMEOUT - 16'd1)) begin
                    pop_s      = 1'b1;
                    timeout_s  = 1'b1;
                    tx_start_d = 1'b0;
                    state_d    = S_IDLE;
                    cnt_d      = 16'd0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                state_d    = S_IDLE;
                tx_start_d = 1'b0;
                cnt_d      = 16'd0;
            end
        endcase
    end

    // Sticky error: a timeout in the same cycle overrides a clear request.
    always_comb begin
        if (timeout_s) begin
            tx_err_d = 1'b1;
        end else if (err_clr) begin
            tx_err_d = 1'b0;
        end else begin
            tx_err_d = tx_err_q;
        end
    end

    // FIFO pointer and occupancy bookkeeping.
    always_comb begin
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + 2'd1;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + 2'd1;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + 3'd1;
            2'b01:   count_d = count_q - 3'd1;
            default: count_d = count_q;
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= 2'd0;
            rd_ptr_q   <= 2'd0;
            count_q    <= 3'd0;
            cnt_q      <= 16'd0;
            tx_start_q <= 1'b0;
            tx_data_q  <= 8'h00;
            tx_err_q   <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                mem_q[i] <= 8'h00;
            end
`ifdef UART_TX_ARB_RR_EN
            rr_q       <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            cnt_q      <= cnt_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            tx_err_q   <= tx_err_d;
            if (push_s) begin
                mem_q[wr_ptr_q] <= push_data_s;
            end
`ifdef UART_TX_ARB_RR_EN
            rr_q       <= rr_d;
`endif
        end
    end

    assign txStart    = tx_start_q;
    assign txData     = tx_data_q;
    assign tx_err     = tx_err_q;
    assign fifo_count = count_q;
    assign fifo_empty = (count_q == 3'd0);
    assign fifo_full  = full_s;

endmodule
